// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory load/store unit.
// Preload constants apply only when DMEM_RESET_INIT_EN is defined.
package dmem_pkg;

  // Access size encoding as carried on req_size
  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_BAD = 2'd3
  } size_e;

  // Access sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int          PRELOAD_WORDS = 4;
  localparam logic [31:0] PRELOAD_0     = 32'd10;
  localparam logic [31:0] PRELOAD_1     = 32'd20;
  localparam logic [31:0] PRELOAD_2     = 32'd30;
  localparam logic [31:0] PRELOAD_3     = 32'd40;

  // Reset image of a word: the first four words carry constants, the rest are zero
  function automatic logic [31:0] preload_word(input int idx);
    case (idx)
      0:       return PRELOAD_0;
      1:       return PRELOAD_1;
      2:       return PRELOAD_2;
      3:       return PRELOAD_3;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational lane logic: byte enables, store-data replication,
// load-lane extraction with sign/zero extension, and alignment/size errors.
module dmem_align
  import dmem_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  addr_lo,
  input  logic        zero_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata,
  output logic        misaligned
);

  logic [31:0] shifted;

  // Move the addressed lane down to bit 0 so extension works on one layout
  assign shifted = rword >> {addr_lo, 3'b000};

  // Decode enables, replicate store data and extend the load lane
  always_comb begin
    be          = 4'b0000;
    wdata_lanes = 32'd0;
    rdata       = 32'd0;
    misaligned  = 1'b0;
    case (size)
      SZ_B: begin
        be          = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
        rdata       = zero_ext ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        be          = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_lanes = {2{wdata[15:0]}};
        rdata       = zero_ext ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        misaligned  = addr_lo[0];
      end
      SZ_W: begin
        be          = 4'b1111;
        wdata_lanes = wdata;
        rdata       = shifted;
        misaligned  = |addr_lo;
      end
      default: begin
        misaligned  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Word-organised data memory behind a valid/ready load/store interface with
// programmable wait states. Define DMEM_RESET_INIT_EN to give the array a
// reset image (words 0..3 = 10,20,30,40, others 0); otherwise it is plain RAM.
module data_mem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int              IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(4 * DEPTH);

  state_e            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              we_reg, zext_reg, err_reg;
  size_e             size_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg, rdata_reg;

  logic              cur_we, cur_zext, enter_resp, err, mem_write, misaligned;
  size_e             cur_size;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata, rword, wdata_lanes, ld_data, merged;
  logic [3:0]        be;
  logic [IDX_W-1:0]  idx;

  logic [31:0] mem [DEPTH];

  // With zero wait states the access completes on the accept edge, so the
  // live request feeds the datapath in IDLE and the latched copy afterwards.
  assign cur_we     = (state_reg == IDLE) ? req_we               : we_reg;
  assign cur_size   = (state_reg == IDLE) ? size_e'(req_size)    : size_reg;
  assign cur_zext   = (state_reg == IDLE) ? req_unsigned         : zext_reg;
  assign cur_addr   = (state_reg == IDLE) ? req_addr             : addr_reg;
  assign cur_wdata  = (state_reg == IDLE) ? req_wdata            : wdata_reg;

  assign idx        = cur_addr[IDX_W+1:2];
  assign rword      = mem[idx];
  assign err        = misaligned || ({1'b0, cur_addr} >= LIMIT);
  assign enter_resp = (state_next == RESP) && (state_reg != RESP);
  assign mem_write  = enter_resp && cur_we && !err;

  dmem_align u_align (
    .size        (cur_size),
    .addr_lo     (cur_addr[1:0]),
    .zero_ext    (cur_zext),
    .wdata       (cur_wdata),
    .rword       (rword),
    .be          (be),
    .wdata_lanes (wdata_lanes),
    .rdata       (ld_data),
    .misaligned  (misaligned)
  );

  // Per-lane merge of new store data over the current word contents
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[gi*8 +: 8] = be[gi] ? wdata_lanes[gi*8 +: 8] : rword[gi*8 +: 8];
    end
  endgenerate

  // Next-state logic: count wait states, hold the response until consumed
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          cnt_next   = 4'd0;
          state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_reg == 4'(WAIT_CYCLES - 1)) state_next = RESP;
        else                                cnt_next   = cnt_reg + 4'd1;
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, request latch and response capture; reset abandons any access
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      we_reg    <= 1'b0;
      size_reg  <= SZ_B;
      zext_reg  <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= 32'd0;
      rdata_reg <= 32'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == IDLE && req_valid) begin
        we_reg    <= req_we;
        size_reg  <= size_e'(req_size);
        zext_reg  <= req_unsigned;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
      end
      if (enter_resp) begin
        rdata_reg <= (cur_we || err) ? 32'd0 : ld_data;
        err_reg   <= err;
      end
    end
  end

`ifdef DMEM_RESET_INIT_EN
  // Memory array with reset image, written on entry to RESP
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= preload_word(i);
    end else if (mem_write) begin
      mem[idx] <= merged;
    end
  end
`else
  // Plain RAM, written on entry to RESP
  always_ff @(posedge clk) begin
    if (mem_write) mem[idx] <= merged;
  end
`endif

  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = (state_reg == RESP);
  assign resp_rdata = resp_valid ? rdata_reg : 32'd0;
  assign resp_err   = resp_valid && err_reg;

endmodule
